// File: rtl/axi4_cfg_slave_pkg.sv
// Shared types and constants for the AXI4 configuration-register responder.
// Response codes and the write/read FSM state encodings live here.
package axi4_cfg_slave_pkg;

    localparam logic [1:0] AXI_RESP_OKAY_C   = 2'b00;
    localparam logic [1:0] AXI_RESP_SLVERR_C = 2'b10;

    typedef enum logic [1:0] {
        WR_IDLE    = 2'd0,
        WR_NEED_W  = 2'd1,
        WR_NEED_AW = 2'd2,
        WR_RESP    = 2'd3
    } wr_state_t;

    typedef enum logic {
        RD_IDLE = 1'b0,
        RD_DATA = 1'b1
    } rd_state_t;

endpackage

// File: rtl/axi4_cfg_rd_engine.sv
// Read side of the configuration responder: accepts incrementing bursts and
// returns one registered beat per cycle from the register vector.
module axi4_cfg_rd_engine
    import axi4_cfg_slave_pkg::*;
#(
    parameter int AXI4_ADDR_WIDTH_P = 16,
    parameter int AXI4_DATA_WIDTH_P = 32,
    parameter int AXI4_STRB_WIDTH_P = 4,
    parameter int NR_OF_REGS_P      = 8
) (
    input  logic                                      clk,
    input  logic                                      rst_n,
    input  logic [NR_OF_REGS_P*AXI4_DATA_WIDTH_P-1:0] regs,
    input  logic [AXI4_ADDR_WIDTH_P-1:0]              araddr,
    input  logic [7:0]                                arlen,
    input  logic                                      arvalid,
    output logic                                      arready,
    output logic [AXI4_DATA_WIDTH_P-1:0]              rdata,
    output logic [1:0]                                rresp,
    output logic                                      rlast,
    output logic                                      rvalid,
    input  logic                                      rready
);

    localparam int LANE_SHIFT_C = $clog2(AXI4_STRB_WIDTH_P);

    rd_state_t                      rd_state_r;
    rd_state_t                      rd_state_s;
    logic [AXI4_DATA_WIDTH_P-1:0]   regs_a [NR_OF_REGS_P];
    logic [AXI4_ADDR_WIDTH_P-1:0]   idx_cur_r;
    logic [AXI4_ADDR_WIDTH_P-1:0]   idx_nxt_s;
    logic [7:0]                     cnt_r;
    logic [7:0]                     cnt_nxt_s;
    logic [7:0]                     len_r;
    logic [7:0]                     len_nxt_s;
    logic                           arready_r;
    logic                           rvalid_r;
    logic                           rlast_r;
    logic [1:0]                     rresp_r;
    logic [AXI4_DATA_WIDTH_P-1:0]   rdata_r;
    logic                           ar_hs_s;
    logic                           r_hs_s;
    logic                           last_hs_s;
    logic                           load_s;
    logic                           nxt_in_range_s;
    logic [AXI4_DATA_WIDTH_P-1:0]   beat_word_s;

    for (genvar k = 0; k < NR_OF_REGS_P; k++) begin : g_unpack
        assign regs_a[k] = regs[k*AXI4_DATA_WIDTH_P +: AXI4_DATA_WIDTH_P];
    end

    assign ar_hs_s   = arvalid && arready_r;
    assign r_hs_s    = rvalid_r && rready;
    assign last_hs_s = r_hs_s && (cnt_r == len_r);
    // A new beat is loaded either at burst start or after a non-final beat handshake.
    assign load_s    = ar_hs_s || (r_hs_s && !last_hs_s);

    // Next-state logic and the address/counter of the beat about to be presented
    always_comb begin
        rd_state_s = rd_state_r;
        case (rd_state_r)
            RD_IDLE: begin
                if (ar_hs_s) begin
                    rd_state_s = RD_DATA;
                end else begin
                    rd_state_s = RD_IDLE;
                end
            end
            RD_DATA: begin
                if (last_hs_s) begin
                    rd_state_s = RD_IDLE;
                end else begin
                    rd_state_s = RD_DATA;
                end
            end
            default: rd_state_s = RD_IDLE;
        endcase

        if (ar_hs_s) begin
            idx_nxt_s = araddr >> LANE_SHIFT_C;
            cnt_nxt_s = 8'd0;
            len_nxt_s = arlen;
        end else begin
            idx_nxt_s = idx_cur_r + {{(AXI4_ADDR_WIDTH_P-1){1'b0}}, 1'b1};
            cnt_nxt_s = cnt_r + 8'd1;
            len_nxt_s = len_r;
        end
    end

    // Register-bank lookup for the upcoming beat; out-of-range beats read as zero
    always_comb begin
        nxt_in_range_s = (idx_nxt_s < AXI4_ADDR_WIDTH_P'(NR_OF_REGS_P));
        beat_word_s    = '0;
        for (int k = 0; k < NR_OF_REGS_P; k++) begin
            beat_word_s = (idx_nxt_s == AXI4_ADDR_WIDTH_P'(k)) ? regs_a[k] : beat_word_s;
        end
    end

    // Burst state, beat counter and registered R-channel payload
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rd_state_r <= RD_IDLE;
            idx_cur_r  <= '0;
            cnt_r      <= 8'd0;
            len_r      <= 8'd0;
            arready_r  <= 1'b0;
            rvalid_r   <= 1'b0;
            rlast_r    <= 1'b0;
            rresp_r    <= AXI_RESP_OKAY_C;
            rdata_r    <= '0;
        end else begin
            rd_state_r <= rd_state_s;
            arready_r  <= (rd_state_s == RD_IDLE);
            if (load_s) begin
                idx_cur_r <= idx_nxt_s;
                cnt_r     <= cnt_nxt_s;
                len_r     <= len_nxt_s;
                rvalid_r  <= 1'b1;
                rlast_r   <= (cnt_nxt_s == len_nxt_s);
                rresp_r   <= nxt_in_range_s ? AXI_RESP_OKAY_C : AXI_RESP_SLVERR_C;
                rdata_r   <= nxt_in_range_s ? beat_word_s : '0;
            end else if (last_hs_s) begin
                rvalid_r  <= 1'b0;
                rlast_r   <= 1'b0;
                rresp_r   <= AXI_RESP_OKAY_C;
                rdata_r   <= '0;
            end else begin
                rvalid_r  <= rvalid_r;
                rlast_r   <= rlast_r;
            end
        end
    end

    assign arready = arready_r;
    assign rvalid  = rvalid_r;
    assign rlast   = rlast_r;
    assign rresp   = rresp_r;
    assign rdata   = rdata_r;

endmodule

// File: rtl/axi4_cfg_slave.sv
// AXI4 configuration-register responder: single-beat strobed writes into a
// register bank, incrementing read bursts served by axi4_cfg_rd_engine.
module axi4_cfg_slave
    import axi4_cfg_slave_pkg::*;
#(
    parameter int AXI4_ID_WIDTH_P   = 2,
    parameter int AXI4_ADDR_WIDTH_P = 16,
    parameter int AXI4_DATA_WIDTH_P = 32,
    parameter int AXI4_STRB_WIDTH_P = 4,
    parameter int NR_OF_REGS_P      = 8
) (
    input  logic                                      clk,
    input  logic                                      rst_n,
    input  logic [AXI4_ADDR_WIDTH_P-1:0]              awaddr,
    input  logic                                      awvalid,
    output logic                                      awready,
    input  logic [AXI4_DATA_WIDTH_P-1:0]              wdata,
    input  logic [AXI4_STRB_WIDTH_P-1:0]              wstrb,
    input  logic                                      wlast,
    input  logic                                      wvalid,
    output logic                                      wready,
    output logic [1:0]                                bresp,
    output logic                                      bvalid,
    input  logic                                      bready,
    input  logic [AXI4_ADDR_WIDTH_P-1:0]              araddr,
    input  logic [7:0]                                arlen,
    input  logic                                      arvalid,
    output logic                                      arready,
    output logic [AXI4_ID_WIDTH_P-1:0]                rid,
    output logic [AXI4_DATA_WIDTH_P-1:0]              rdata,
    output logic [1:0]                                rresp,
    output logic                                      rlast,
    output logic                                      rvalid,
    input  logic                                      rready,
    output logic [NR_OF_REGS_P*AXI4_DATA_WIDTH_P-1:0] cfg_regs,
    output logic [NR_OF_REGS_P-1:0]                   cfg_wr
);

    localparam int LANE_SHIFT_C = $clog2(AXI4_STRB_WIDTH_P);

    wr_state_t                      wr_state_r;
    wr_state_t                      wr_state_s;
    logic [AXI4_DATA_WIDTH_P-1:0]   regs_r [NR_OF_REGS_P];
    logic [AXI4_ADDR_WIDTH_P-1:0]   awaddr_r;
    logic [AXI4_DATA_WIDTH_P-1:0]   wdata_r;
    logic [AXI4_STRB_WIDTH_P-1:0]   wstrb_r;
    logic                           awready_r;
    logic                           wready_r;
    logic                           bvalid_r;
    logic [1:0]                     bresp_r;
    logic [NR_OF_REGS_P-1:0]        cfg_wr_r;
    logic                           aw_hs_s;
    logic                           w_hs_s;
    logic                           commit_s;
    logic [AXI4_ADDR_WIDTH_P-1:0]   wr_idx_s;
    logic [AXI4_DATA_WIDTH_P-1:0]   wr_data_s;
    logic [AXI4_STRB_WIDTH_P-1:0]   wr_strb_s;
    logic                           wr_in_range_s;
    logic                           unused_wlast_s;

    function automatic logic [AXI4_DATA_WIDTH_P-1:0] merge_bytes(
        input logic [AXI4_DATA_WIDTH_P-1:0] old_word,
        input logic [AXI4_DATA_WIDTH_P-1:0] new_word,
        input logic [AXI4_STRB_WIDTH_P-1:0] strb
    );
        logic [AXI4_DATA_WIDTH_P-1:0] merged;
        merged = old_word;
        for (int i = 0; i < AXI4_STRB_WIDTH_P; i++) begin
            merged[i*8 +: 8] = strb[i] ? new_word[i*8 +: 8] : old_word[i*8 +: 8];
        end
        return merged;
    endfunction

    // Every write is a single beat, so wlast carries no information.
    assign unused_wlast_s = wlast;

    assign aw_hs_s = awvalid && awready_r;
    assign w_hs_s  = wvalid && wready_r;

    // Write FSM next state; the commit happens on the edge that enters WR_RESP
    always_comb begin
        wr_state_s = wr_state_r;
        case (wr_state_r)
            WR_IDLE: begin
                if (aw_hs_s && w_hs_s) begin
                    wr_state_s = WR_RESP;
                end else if (aw_hs_s) begin
                    wr_state_s = WR_NEED_W;
                end else if (w_hs_s) begin
                    wr_state_s = WR_NEED_AW;
                end else begin
                    wr_state_s = WR_IDLE;
                end
            end
            WR_NEED_W: begin
                if (w_hs_s) begin
                    wr_state_s = WR_RESP;
                end else begin
                    wr_state_s = WR_NEED_W;
                end
            end
            WR_NEED_AW: begin
                if (aw_hs_s) begin
                    wr_state_s = WR_RESP;
                end else begin
                    wr_state_s = WR_NEED_AW;
                end
            end
            WR_RESP: begin
                if (bready) begin
                    wr_state_s = WR_IDLE;
                end else begin
                    wr_state_s = WR_RESP;
                end
            end
            default: wr_state_s = WR_IDLE;
        endcase
    end

    // Select live bus values when a channel handshakes now, latched values otherwise
    always_comb begin
        wr_idx_s      = (aw_hs_s ? awaddr : awaddr_r) >> LANE_SHIFT_C;
        wr_data_s     = w_hs_s ? wdata : wdata_r;
        wr_strb_s     = w_hs_s ? wstrb : wstrb_r;
        wr_in_range_s = (wr_idx_s < AXI4_ADDR_WIDTH_P'(NR_OF_REGS_P));
        commit_s      = (wr_state_s == WR_RESP) && (wr_state_r != WR_RESP);
    end

    // Write-path state, channel readies, B response and the register bank
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_state_r <= WR_IDLE;
            awready_r  <= 1'b0;
            wready_r   <= 1'b0;
            bvalid_r   <= 1'b0;
            bresp_r    <= AXI_RESP_OKAY_C;
            cfg_wr_r   <= '0;
            awaddr_r   <= '0;
            wdata_r    <= '0;
            wstrb_r    <= '0;
            for (int k = 0; k < NR_OF_REGS_P; k++) begin
                regs_r[k] <= '0;
            end
        end else begin
            wr_state_r <= wr_state_s;
            awready_r  <= (wr_state_s == WR_IDLE) || (wr_state_s == WR_NEED_AW);
            wready_r   <= (wr_state_s == WR_IDLE) || (wr_state_s == WR_NEED_W);
            bvalid_r   <= (wr_state_s == WR_RESP);
            cfg_wr_r   <= '0;
            if (aw_hs_s) begin
                awaddr_r <= awaddr;
            end
            if (w_hs_s) begin
                wdata_r <= wdata;
                wstrb_r <= wstrb;
            end
            if (commit_s) begin
                bresp_r <= wr_in_range_s ? AXI_RESP_OKAY_C : AXI_RESP_SLVERR_C;
                for (int k = 0; k < NR_OF_REGS_P; k++) begin
                    if (wr_in_range_s && (wr_idx_s == AXI4_ADDR_WIDTH_P'(k))) begin
                        regs_r[k]   <= merge_bytes(regs_r[k], wr_data_s, wr_strb_s);
                        cfg_wr_r[k] <= 1'b1;
                    end
                end
            end
        end
    end

    for (genvar k = 0; k < NR_OF_REGS_P; k++) begin : g_flat
        assign cfg_regs[k*AXI4_DATA_WIDTH_P +: AXI4_DATA_WIDTH_P] = regs_r[k];
    end

    assign awready = awready_r;
    assign wready  = wready_r;
    assign bvalid  = bvalid_r;
    assign bresp   = bresp_r;
    assign cfg_wr  = cfg_wr_r;
    // No arid on this interface, so every read reports ID zero.
    assign rid     = '0;

    axi4_cfg_rd_engine #(
        .AXI4_ADDR_WIDTH_P (AXI4_ADDR_WIDTH_P),
        .AXI4_DATA_WIDTH_P (AXI4_DATA_WIDTH_P),
        .AXI4_STRB_WIDTH_P (AXI4_STRB_WIDTH_P),
        .NR_OF_REGS_P      (NR_OF_REGS_P)
    ) u_rd_engine (
        .clk     (clk),
        .rst_n   (rst_n),
        .regs    (cfg_regs),
        .araddr  (araddr),
        .arlen   (arlen),
        .arvalid (arvalid),
        .arready (arready),
        .rdata   (rdata),
        .rresp   (rresp),
        .rlast   (rlast),
        .rvalid  (rvalid),
        .rready  (rready)
    );

endmodule

// File: tb/tb_axi4_cfg_slave.sv
// Self-checking bench for axi4_cfg_slave: directed scenarios plus randomized
// write/read traffic compared against a plain register-array reference model.
module tb_axi4_cfg_slave;

    logic         clk;
    logic         rst_n;
    logic [15:0]  awaddr;
    logic         awvalid;
    logic         awready;
    logic [31:0]  wdata;
    logic [3:0]   wstrb;
    logic         wlast;
    logic         wvalid;
    logic         wready;
    logic [1:0]   bresp;
    logic         bvalid;
    logic         bready;
    logic [15:0]  araddr;
    logic [7:0]   arlen;
    logic         arvalid;
    logic         arready;
    logic [1:0]   rid;
    logic [31:0]  rdata;
    logic [1:0]   rresp;
    logic         rlast;
    logic         rvalid;
    logic         rready;
    logic [255:0] cfg_regs;
    logic [7:0]   cfg_wr;

    int          checks;
    int          failures;
    logic [31:0] model [8];

    axi4_cfg_slave dut (
        .clk(clk), .rst_n(rst_n),
        .awaddr(awaddr), .awvalid(awvalid), .awready(awready),
        .wdata(wdata), .wstrb(wstrb), .wlast(wlast), .wvalid(wvalid), .wready(wready),
        .bresp(bresp), .bvalid(bvalid), .bready(bready),
        .araddr(araddr), .arlen(arlen), .arvalid(arvalid), .arready(arready),
        .rid(rid), .rdata(rdata), .rresp(rresp), .rlast(rlast), .rvalid(rvalid), .rready(rready),
        .cfg_regs(cfg_regs), .cfg_wr(cfg_wr)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic check_bank(input string tag);
        for (int k = 0; k < 8; k++) begin
            check(tag, cfg_regs[k*32 +: 32], model[k]);
        end
    endtask

    task automatic do_write(input logic [15:0] addr, input logic [31:0] data, input logic [3:0] strb,
                            input int aw_dly, input int w_dly, input int b_dly);
        bit aw_done;
        bit w_done;
        bit aw_fire;
        bit w_fire;
        int cyc;
        int idx;
        logic [7:0] exp_wr;
        aw_done = 1'b0;
        w_done  = 1'b0;
        cyc     = 0;
        idx     = int'(addr >> 2);
        while (!(aw_done && w_done) && cyc < 20) begin
            awvalid = !aw_done && (cyc >= aw_dly);
            awaddr  = addr;
            wvalid  = !w_done && (cyc >= w_dly);
            wdata   = data;
            wstrb   = strb;
            aw_fire = awvalid && awready;
            w_fire  = wvalid && wready;
            tick();
            cyc++;
            if (aw_fire) aw_done = 1'b1;
            if (w_fire)  w_done  = 1'b1;
            if (aw_done && !w_done) begin
                check("awready_after_aw", {31'd0, awready}, 32'd0);
                check("wready_need_w", {31'd0, wready}, 32'd1);
            end
            if (w_done && !aw_done) begin
                check("wready_after_w", {31'd0, wready}, 32'd0);
                check("awready_need_aw", {31'd0, awready}, 32'd1);
            end
        end
        awvalid = 1'b0;
        wvalid  = 1'b0;
        check("wr_handshake_timeout", {31'd0, aw_done && w_done}, 32'd1);
        exp_wr = 8'd0;
        if (idx < 8) begin
            for (int b = 0; b < 4; b++) begin
                if (strb[b]) model[idx][b*8 +: 8] = data[b*8 +: 8];
            end
            exp_wr[idx] = 1'b1;
        end
        check("bvalid_latency", {31'd0, bvalid}, 32'd1);
        check("bresp", {30'd0, bresp}, (idx < 8) ? 32'd0 : 32'd2);
        check("cfg_wr_pulse", {24'd0, cfg_wr}, {24'd0, exp_wr});
        check("resp_awready", {31'd0, awready}, 32'd0);
        check("resp_wready", {31'd0, wready}, 32'd0);
        check_bank("bank_after_write");
        for (int i = 0; i < b_dly; i++) begin
            tick();
            check("bvalid_hold", {31'd0, bvalid}, 32'd1);
            check("bresp_hold", {30'd0, bresp}, (idx < 8) ? 32'd0 : 32'd2);
            check("cfg_wr_one_cycle", {24'd0, cfg_wr}, 32'd0);
        end
        bready = 1'b1;
        tick();
        bready = 1'b0;
        check("bvalid_cleared", {31'd0, bvalid}, 32'd0);
        check("cfg_wr_cleared", {24'd0, cfg_wr}, 32'd0);
    endtask

    task automatic do_read(input logic [15:0] addr, input logic [7:0] len, input bit toggle);
        int beat;
        int cyc;
        int idx;
        check("arready_idle", {31'd0, arready}, 32'd1);
        arvalid = 1'b1;
        araddr  = addr;
        arlen   = len;
        tick();
        arvalid = 1'b0;
        check("arready_busy", {31'd0, arready}, 32'd0);
        check("rid_zero", {30'd0, rid}, 32'd0);
        beat = 0;
        cyc  = 0;
        while (beat <= int'(len) && cyc < 800) begin
            idx = int'(addr >> 2) + beat;
            check("rvalid", {31'd0, rvalid}, 32'd1);
            check("rdata", rdata, (idx < 8) ? model[idx] : 32'd0);
            check("rresp", {30'd0, rresp}, (idx < 8) ? 32'd0 : 32'd2);
            check("rlast", {31'd0, rlast}, {31'd0, beat == int'(len)});
            rready = toggle ? 1'($urandom_range(0, 1)) : 1'b1;
            tick();
            cyc++;
            if (rready) beat++;
        end
        rready = 1'b0;
        check("rd_beat_timeout", beat, int'(len) + 1);
        check("rvalid_after_burst", {31'd0, rvalid}, 32'd0);
        check("arready_after_burst", {31'd0, arready}, 32'd1);
    endtask

    initial begin
        logic [31:0] old_val;
        checks   = 0;
        failures = 0;
        clk      = 1'b0;
        rst_n    = 1'b0;
        awaddr   = 16'd0; awvalid = 1'b0;
        wdata    = 32'd0; wstrb = 4'd0; wlast = 1'b1; wvalid = 1'b0;
        bready   = 1'b0;
        araddr   = 16'd0; arlen = 8'd0; arvalid = 1'b0;
        rready   = 1'b0;
        for (int k = 0; k < 8; k++) model[k] = 32'd0;

        // Reset values
        tick();
        tick();
        check("rst_awready", {31'd0, awready}, 32'd0);
        check("rst_wready", {31'd0, wready}, 32'd0);
        check("rst_arready", {31'd0, arready}, 32'd0);
        check("rst_bvalid", {31'd0, bvalid}, 32'd0);
        check("rst_bresp", {30'd0, bresp}, 32'd0);
        check("rst_rvalid", {31'd0, rvalid}, 32'd0);
        check("rst_rlast", {31'd0, rlast}, 32'd0);
        check("rst_rdata", rdata, 32'd0);
        check("rst_rresp", {30'd0, rresp}, 32'd0);
        check("rst_cfg_wr", {24'd0, cfg_wr}, 32'd0);
        check_bank("rst_bank");
        rst_n = 1'b1;
        tick();
        check("post_rst_awready", {31'd0, awready}, 32'd1);
        check("post_rst_wready", {31'd0, wready}, 32'd1);
        check("post_rst_arready", {31'd0, arready}, 32'd1);

        // Same-cycle AW/W, W before AW with a long B stall, out-of-range write
        do_write(16'h0008, 32'hDEADBEEF, 4'hF, 0, 0, 0);
        do_write(16'h0004, 32'h12345678, 4'h3, 3, 0, 5);
        check("reg1_partial", cfg_regs[63:32], 32'h00005678);
        do_write(16'h0020, 32'hCAFEF00D, 4'hF, 0, 0, 1);
        do_write(16'h000C, 32'h0BADC0DE, 4'hF, 0, 2, 0);

        // Burst crossing the top of the bank with rready toggling
        do_write(16'h0018, $urandom, 4'hF, 0, 0, 0);
        do_write(16'h001C, $urandom, 4'hF, 0, 0, 0);
        do_read(16'h0018, 8'd3, 1'b1);

        // Write to reg0 lands on the cycle its read beat handshakes
        old_val = model[0];
        arvalid = 1'b1; araddr = 16'h0000; arlen = 8'd0;
        tick();
        arvalid = 1'b0;
        awvalid = 1'b1; awaddr = 16'h0000;
        wvalid  = 1'b1; wdata = 32'hA5A5A5A5; wstrb = 4'hF;
        rready  = 1'b1;
        check("concurrent_rvalid", {31'd0, rvalid}, 32'd1);
        check("concurrent_old_value", rdata, old_val);
        tick();
        awvalid = 1'b0; wvalid = 1'b0; rready = 1'b0;
        model[0] = 32'hA5A5A5A5;
        check("concurrent_reg0_written", cfg_regs[31:0], 32'hA5A5A5A5);
        check("concurrent_bvalid", {31'd0, bvalid}, 32'd1);
        check("concurrent_rvalid_done", {31'd0, rvalid}, 32'd0);
        bready = 1'b1;
        tick();
        bready = 1'b0;
        do_read(16'h0000, 8'd0, 1'b0);

        // Randomized mix of writes and bursts
        for (int n = 0; n < 40; n++) begin
            if ($urandom_range(0, 1) == 0) begin
                do_write(16'($urandom_range(0, 9) * 4 + $urandom_range(0, 3)), $urandom,
                         4'($urandom_range(0, 15)), $urandom_range(0, 3), $urandom_range(0, 3),
                         $urandom_range(0, 2));
            end else begin
                do_read(16'($urandom_range(0, 9) * 4 + $urandom_range(0, 3)),
                        8'($urandom_range(0, 10)), 1'($urandom_range(0, 1)));
            end
        end

        // Reset while beat 2 of an 8-beat burst is on the bus
        arvalid = 1'b1; araddr = 16'h0000; arlen = 8'd7;
        tick();
        arvalid = 1'b0;
        rready  = 1'b1;
        tick();
        check("midburst_beat2_valid", {31'd0, rvalid}, 32'd1);
        check("midburst_beat2_data", rdata, model[1]);
        rst_n = 1'b0;
        #1;
        for (int k = 0; k < 8; k++) model[k] = 32'd0;
        check("midburst_rvalid", {31'd0, rvalid}, 32'd0);
        check("midburst_rlast", {31'd0, rlast}, 32'd0);
        check("midburst_arready", {31'd0, arready}, 32'd0);
        check_bank("midburst_bank");
        rready = 1'b0;
        tick();
        tick();
        rst_n = 1'b1;
        tick();
        check("midburst_arready_release", {31'd0, arready}, 32'd1);
        check("midburst_rvalid_release", {31'd0, rvalid}, 32'd0);
        do_read(16'h0004, 8'd1, 1'b0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
